// File: rtl/clock_adjust_ctrl.sv
// rtl/clock_adjust_ctrl.sv - mode/adjust sequencer, 1 Hz timebase and alarm ring control
//
// Purpose: steps the adjust-field selector on the mode key, gates the inc/dec
// key pulses to the selected counter, freezes the seconds count enable while
// the time fields are edited, auto-exits adjust mode after an idle period and
// times the alarm ring.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_key1_p              mode key pulse
//   i_key2_p              increment key pulse (alarm arm toggle in RUN)
//   i_key3_p              decrement key pulse
//   i_cur_time [23:0]     current time, BCD hh:mm:ss
//   i_alm_time [15:0]     alarm time, BCD hh:mm
//   o_adjust   [2:0]      selected field (0 RUN .. 5 ALM_HOUR)
//   o_tick_1s             one-cycle pulse every CNT_1S cycles
//   o_cnt_en              seconds counter enable
//   o_inc_p, o_dec_p      gated increment / decrement pulses
//   o_alarm_en            alarm armed
//   o_ring                alarm sounding
module clock_adjust_ctrl #(
  parameter int CNT_1S    = 50_000_000,
  parameter int IDLE_SECS = 10,
  parameter int RING_SECS = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_key1_p,
  input  logic        i_key2_p,
  input  logic        i_key3_p,
  input  logic [23:0] i_cur_time,
  input  logic [15:0] i_alm_time,
  output logic [2:0]  o_adjust,
  output logic        o_tick_1s,
  output logic        o_cnt_en,
  output logic        o_inc_p,
  output logic        o_dec_p,
  output logic        o_alarm_en,
  output logic        o_ring
);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SEC      = 3'd1,
    ST_MIN      = 3'd2,
    ST_HOUR     = 3'd3,
    ST_ALM_MIN  = 3'd4,
    ST_ALM_HOUR = 3'd5
  } state_t;

  localparam int PW = (CNT_1S > 1) ? $clog2(CNT_1S) : 1;
  localparam int IW = $clog2(IDLE_SECS + 1);
  localparam int RW = $clog2(RING_SECS + 1);
  localparam logic [PW-1:0] P_LAST = PW'(CNT_1S - 1);
  localparam logic [IW-1:0] I_LAST = IW'(IDLE_SECS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RING_SECS - 1);

  state_t          r_state, w_state_next;
  logic [PW-1:0]   r_presc, w_presc_next;
  logic [IW-1:0]   r_idle, w_idle_next;
  logic [RW-1:0]   r_ring_cnt, w_ring_cnt_next;
  logic            r_tick, r_cnt_en, r_inc, r_dec, r_alarm_en, r_ring;
  logic            w_wrap, w_cnt_en_next, w_inc_next, w_dec_next;
  logic            w_alarm_next, w_ring_next;
  logic            w_any_key, w_valid, w_in_adj, w_trigger;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_RUN;
      r_presc    <= '0;
      r_idle     <= '0;
      r_ring_cnt <= '0;
      r_tick     <= 1'b0;
      r_cnt_en   <= 1'b0;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_alarm_en <= 1'b0;
      r_ring     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_presc    <= w_presc_next;
      r_idle     <= w_idle_next;
      r_ring_cnt <= w_ring_cnt_next;
      r_tick     <= w_wrap;
      r_cnt_en   <= w_cnt_en_next;
      r_inc      <= w_inc_next;
      r_dec      <= w_dec_next;
      r_alarm_en <= w_alarm_next;
      r_ring     <= w_ring_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_idle_next     = r_idle;
    w_ring_cnt_next = r_ring_cnt;
    w_inc_next      = 1'b0;
    w_dec_next      = 1'b0;
    w_alarm_next    = r_alarm_en;
    w_ring_next     = r_ring;

    w_wrap       = (r_presc == P_LAST);
    w_presc_next = w_wrap ? '0 : r_presc + PW'(1);
    w_any_key    = i_key1_p | i_key2_p | i_key3_p;

    case (r_state)
      ST_RUN, ST_SEC, ST_MIN, ST_HOUR, ST_ALM_MIN, ST_ALM_HOUR: w_valid = 1'b1;
      default:                                                  w_valid = 1'b0;
    endcase
    w_in_adj = w_valid && (r_state != ST_RUN);

    // Key decode: a key while ringing only silences; otherwise key1 > key2 > key3.
    if (!w_valid) begin
      w_state_next = ST_RUN;
    end else if (r_ring && w_any_key) begin
      w_state_next = r_state;
    end else if (i_key1_p) begin
      w_state_next = (r_state == ST_ALM_HOUR) ? ST_RUN : state_t'(r_state + 3'd1);
    end else if (i_key2_p) begin
      if (w_in_adj) w_inc_next = 1'b1;
      else          w_alarm_next = ~r_alarm_en;
    end else if (i_key3_p) begin
      if (w_in_adj) w_dec_next = 1'b1;
    end else if (w_in_adj && r_tick && (r_idle == I_LAST)) begin
      w_state_next = ST_RUN;
    end

    if (w_any_key || (w_state_next == ST_RUN)) w_idle_next = '0;
    else if (w_in_adj && r_tick)               w_idle_next = r_idle + IW'(1);

    // Follows the state being entered so cnt_en always agrees with o_adjust.
    w_cnt_en_next = w_wrap && ((w_state_next == ST_RUN) || (w_state_next == ST_ALM_MIN) ||
                               (w_state_next == ST_ALM_HOUR));

    w_trigger = r_alarm_en && (i_cur_time[23:8] == i_alm_time) &&
                (i_cur_time[7:0] == 8'h00) && r_cnt_en;

    if (w_trigger) begin
      w_ring_next     = 1'b1;
      w_ring_cnt_next = '0;
    end else if (r_ring) begin
      if (w_any_key || !r_alarm_en) begin
        w_ring_next     = 1'b0;
        w_ring_cnt_next = '0;
      end else if (r_tick) begin
        if (r_ring_cnt == R_LAST) begin
          w_ring_next     = 1'b0;
          w_ring_cnt_next = '0;
        end else begin
          w_ring_cnt_next = r_ring_cnt + RW'(1);
        end
      end
    end
  end

  assign o_adjust   = r_state;
  assign o_tick_1s  = r_tick;
  assign o_cnt_en   = r_cnt_en;
  assign o_inc_p    = r_inc;
  assign o_dec_p    = r_dec;
  assign o_alarm_en = r_alarm_en;
  assign o_ring     = r_ring;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// tb/tb_clock_adjust_ctrl.sv - directed self-checking bench for clock_adjust_ctrl
module tb_clock_adjust_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key1 = 1'b0, key2 = 1'b0, key3 = 1'b0;
  logic [23:0] cur_time = 24'h000001;
  logic [15:0] alm_time = 16'h1234;
  logic [2:0]  adjust;
  logic        tick_1s, cnt_en, inc_p, dec_p, alarm_en, ring;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int e_adj    = 0;

  always #5 clk = ~clk;

  clock_adjust_ctrl #(.CNT_1S(4), .IDLE_SECS(3), .RING_SECS(5)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_key1_p(key1), .i_key2_p(key2), .i_key3_p(key3),
    .i_cur_time(cur_time), .i_alm_time(alm_time),
    .o_adjust(adjust), .o_tick_1s(tick_1s), .o_cnt_en(cnt_en),
    .o_inc_p(inc_p), .o_dec_p(dec_p), .o_alarm_en(alarm_en), .o_ring(ring)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock edge after release; tick expected every 4th cycle, cnt_en only
  // when the field being entered is RUN/ALM_MIN/ALM_HOUR.
  task automatic tick();
    logic exp_t;
    @(posedge clk);
    #1;
    cyc++;
    exp_t = (cyc % 4 == 0);
    check("tick_1s", int'(tick_1s), int'(exp_t));
    check("cnt_en", int'(cnt_en), int'(exp_t && (e_adj == 0 || e_adj >= 4)));
  endtask

  task automatic drive(input logic k1, input logic k2, input logic k3);
    key1 = k1; key2 = k2; key3 = k3;
    tick();
    key1 = 1'b0; key2 = 1'b0; key3 = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_adjust"}, int'(adjust), 0);
    check({tag, "_tick"}, int'(tick_1s), 0);
    check({tag, "_cnt_en"}, int'(cnt_en), 0);
    check({tag, "_inc"}, int'(inc_p), 0);
    check({tag, "_dec"}, int'(dec_p), 0);
    check({tag, "_alarm_en"}, int'(alarm_en), 0);
    check({tag, "_ring"}, int'(ring), 0);
  endtask

  initial begin
    // Reset and timebase
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (13) tick();

    // Mode walk; inc at HOUR in the gap after the third step
    for (int i = 1; i <= 6; i++) begin
      e_adj = i % 6;
      drive(1'b1, 1'b0, 1'b0);
      check("walk_adjust", int'(adjust), e_adj);
      check("walk_no_inc", int'(inc_p), 0);
      if (i == 3) begin
        drive(1'b0, 1'b1, 1'b0);
        check("hour_inc", int'(inc_p), 1);
        check("hour_no_toggle", int'(alarm_en), 0);
      end else begin
        drive(1'b0, 1'b0, 1'b0);
      end
    end

    // key2 in RUN toggles arm, never increments
    drive(1'b0, 1'b1, 1'b0);
    check("run_toggle_on", int'(alarm_en), 1);
    check("run_no_inc", int'(inc_p), 0);
    drive(1'b0, 1'b1, 1'b0);
    check("run_toggle_off", int'(alarm_en), 0);

    // Simultaneous keys
    e_adj = 1;
    drive(1'b1, 1'b1, 1'b0);
    check("k1k2_adjust", int'(adjust), 1);
    check("k1k2_no_inc", int'(inc_p), 0);
    check("k1k2_alarm_en", int'(alarm_en), 0);
    e_adj = 2;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    check("k2k3_inc", int'(inc_p), 1);
    check("k2k3_no_dec", int'(dec_p), 0);
    for (int i = 3; i <= 6; i++) begin
      e_adj = i % 6;
      drive(1'b1, 1'b0, 1'b0);
    end
    check("back_to_run", int'(adjust), 0);

    // Idle timeout: enter SEC at cycle 35, key3 after the 2nd tick restarts
    e_adj = 1;
    drive(1'b1, 1'b0, 1'b0);
    while (cyc < 41) tick();
    drive(1'b0, 1'b0, 1'b1);
    check("idle_dec", int'(dec_p), 1);
    check("idle_adjust_after_key", int'(adjust), 1);
    while (cyc < 52) begin
      tick();
      check("idle_hold", int'(adjust), 1);
    end
    e_adj = 0;
    tick();
    check("idle_timeout", int'(adjust), 0);

    // Alarm: arm, match on the tick at cycle 56, ring from 57 through 76
    drive(1'b0, 1'b1, 1'b0);
    check("arm", int'(alarm_en), 1);
    alm_time = 16'h0730;
    cur_time = 24'h073000;
    while (cyc < 56) tick();
    check("ring_before", int'(ring), 0);
    tick();
    check("ring_set", int'(ring), 1);
    cur_time = 24'h073001;
    while (cyc < 76) begin
      tick();
      check("ring_hold", int'(ring), 1);
    end
    tick();
    check("ring_timeout", int'(ring), 0);
    check("ring_timeout_armed", int'(alarm_en), 1);

    // Ring again, silenced by key3
    cur_time = 24'h073000;
    while (cyc < 81) tick();
    check("ring2_set", int'(ring), 1);
    cur_time = 24'h073001;
    drive(1'b0, 1'b0, 1'b1);
    check("silence_ring", int'(ring), 0);
    check("silence_armed", int'(alarm_en), 1);
    check("silence_adjust", int'(adjust), 0);
    check("silence_no_dec", int'(dec_p), 0);

    // Ring again, key1 is consumed by the silence
    cur_time = 24'h073000;
    while (cyc < 85) tick();
    check("ring3_set", int'(ring), 1);
    cur_time = 24'h073001;
    drive(1'b1, 1'b0, 1'b0);
    check("k1_silence_ring", int'(ring), 0);
    check("k1_consumed", int'(adjust), 0);

    // Reset while ringing in ALM_MIN
    for (int i = 1; i <= 4; i++) begin
      e_adj = i;
      drive(1'b1, 1'b0, 1'b0);
    end
    cur_time = 24'h073000;
    while (cyc < 93) tick();
    check("pre_rst_ring", int'(ring), 1);
    check("pre_rst_adjust", int'(adjust), 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    rst = 1'b0;
    cur_time = 24'h000001;
    cyc = 0;
    e_adj = 0;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
